// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter
//   Writeback stage merging ALU and load-unit results into the single
//   byte-enabled GPR write port. ALU results are never stalled and always
//   win; load results are queued in a small FIFO and drain on cycles the
//   ALU leaves free. When the FIFO is empty and the ALU is idle, an
//   accepted load bypasses the FIFO straight into the output register.
//
// Parameters
//   LDQ_DEPTH  load FIFO entries (power of two, 2..16)
//   TID_MSB    thread id MSB; sets the default address width
//   AW         regfile address width; wa[5:0] = register, upper bits = thread
//
// Ports
//   clk, rst                      clock, async active-high reset
//   alu_v/alu_wa/alu_sel/alu_res  ALU result (always accepted)
//   ld_v/ld_rdy/ld_wa/ld_sel/ld_res  load result, valid/ready handshake
//   wr/wa/o                       registered regfile write port
//   ldq_cnt                       FIFO occupancy
//   rq_a/rq_hit                   combinational pending-write hazard query
//
// Build option
//   GPR_WB_R0_SUPPRESS_EN  when defined, writes to register 0 of any thread
//                          (wa[5:0] == 0) are issued with wr = 0 and never
//                          raise rq_hit.

module gpr_wb_arbiter #(
    parameter int LDQ_DEPTH = 4,
    parameter int TID_MSB   = 0,
    parameter int AW        = 5 + TID_MSB + 2
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         alu_v,
    input  logic [AW-1:0]                alu_wa,
    input  logic [3:0]                   alu_sel,
    input  logic [31:0]                  alu_res,

    input  logic                         ld_v,
    output logic                         ld_rdy,
    input  logic [AW-1:0]                ld_wa,
    input  logic [3:0]                   ld_sel,
    input  logic [31:0]                  ld_res,

    output logic [3:0]                   wr,
    output logic [AW-1:0]                wa,
    output logic [31:0]                  o,

    output logic [$clog2(LDQ_DEPTH):0]   ldq_cnt,

    input  logic [AW-1:0]                rq_a,
    output logic                         rq_hit
);

    localparam int PW = $clog2(LDQ_DEPTH);
    localparam int CW = PW + 1;

    // FIFO storage
    logic [AW-1:0]  q_wa  [LDQ_DEPTH];
    logic [3:0]     q_sel [LDQ_DEPTH];
    logic [31:0]    q_res [LDQ_DEPTH];

    logic [PW-1:0]  wp;
    logic [PW-1:0]  rp;
    logic [CW-1:0]  cnt;

    logic           empty;
    logic           ld_acc;
    logic           enq;
    logic           deq;

    logic [3:0]     alu_sel_eff;
    logic [3:0]     ld_sel_eff;

    // Register-0 suppression is folded into the byte enables at the input,
    // so queued r0 writes carry sel = 0 and drop out of the hazard query
    // without a separate compare on the FIFO contents.
`ifdef GPR_WB_R0_SUPPRESS_EN
    assign alu_sel_eff = (alu_wa[5:0] == 6'd0) ? 4'h0 : alu_sel;
    assign ld_sel_eff  = (ld_wa[5:0]  == 6'd0) ? 4'h0 : ld_sel;
`else
    assign alu_sel_eff = alu_sel;
    assign ld_sel_eff  = ld_sel;
`endif

    assign empty   = (cnt == '0);
    assign ld_rdy  = (cnt != CW'(LDQ_DEPTH));
    assign ld_acc  = ld_v & ld_rdy;

    // Loads bypass only when nothing is ahead of them and the ALU is idle;
    // otherwise they queue, which keeps load order intact.
    assign enq     = ld_acc & (alu_v | ~empty);
    assign deq     = ~alu_v & ~empty;

    assign ldq_cnt = cnt;

    // Pointer / count bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (enq) begin
                wp <= wp + 1'b1;
            end
            if (deq) begin
                rp <= rp + 1'b1;
            end
            if (enq && !deq) begin
                cnt <= cnt + 1'b1;
            end else if (deq && !enq) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Storage is never read outside the valid window, so it needs no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_wa[wp]  <= ld_wa;
            q_sel[wp] <= ld_sel_eff;
            q_res[wp] <= ld_res;
        end
    end

    // Output register: ALU > FIFO head > bypassed load > idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr <= '0;
            wa <= '0;
            o  <= '0;
        end else if (alu_v) begin
            wr <= alu_sel_eff;
            wa <= alu_wa;
            o  <= alu_res;
        end else if (!empty) begin
            wr <= q_sel[rp];
            wa <= q_wa[rp];
            o  <= q_res[rp];
        end else if (ld_acc) begin
            wr <= ld_sel_eff;
            wa <= ld_wa;
            o  <= ld_res;
        end else begin
            wr <= '0;
        end
    end

    // Hazard query: an entry is live when its distance from the read
    // pointer (mod depth) is below the occupancy count.
    always_comb begin
        logic [PW-1:0] off;
        rq_hit = (wr != 4'h0) && (wa == rq_a);
        for (int unsigned i = 0; i < LDQ_DEPTH; i++) begin
            off = PW'(i) - rp;
            if ((CW'(off) < cnt) && (q_sel[i] != 4'h0) && (q_wa[i] == rq_a)) begin
                rq_hit = 1'b1;
            end
        end
    end

endmodule
